arbitro_memoria: RTL and testbench

Two-requester arbiter and sequencer for the single-port synchronous data memory shared by the processor (requester 0) and the I/O loader/DMA port (requester 1). It grants one requester at a time, drives the memory address, write-enable and write data for a single access, waits out the memory read latency, returns read data, and acknowledges completion. It sits between the processor's AddressOut/DOUT/Write/DIN signals and the RAM.

---
 rtl/arbitro_memoria.sv | 136 +++++++++++++
 tb/tb_arbitro_memoria.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: two-requester arbiter and access sequencer for the shared
// single-port synchronous data memory. Requester 0 is the processor and
// requester 1 is the I/O loader/DMA port. One access is in flight at a time.
// A read waits out the RAM read latency before RData and Ack are returned.
module arbitro_memoria #(
  parameter int RD_LAT    = 1,    // RAM read latency in cycles, 1..3
  parameter bit PRIO_FIXA = 1'b0  // 1: requester 0 always wins a tie
) (
  input  logic        Clock,
  input  logic        Resetn,     // active-high despite the name
  input  logic        Req0,
  input  logic [15:0] Addr0,
  input  logic        Wr0,
  input  logic [15:0] Data0,
  input  logic        Req1,
  input  logic [15:0] Addr1,
  input  logic        Wr1,
  input  logic [15:0] Data1,
  input  logic [15:0] MemDataIn,
  output logic [15:0] MemAddr,
  output logic [15:0] MemDataOut,
  output logic        MemWrEn,
  output logic [15:0] RData,
  output logic        Ack0,
  output logic        Ack1,
  output logic [1:0]  Grant,
  output logic        Busy
);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACESSO  = 2'd1,
    ESPERA  = 2'd2,
    CONCLUI = 2'd3
  } estado_t;

  localparam logic [1:0] LAT_INI = 2'(RD_LAT);

  estado_t    state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       wr_q;       // access type captured at grant
  logic       ultimo;     // last requester served (1 = requester 1)
  logic       pick1;      // arbitration result: requester 1 wins
  logic       take;       // grant happens at this edge
  logic       grab;       // capture read data at this edge

  // State register and read-latency counter.
  always_ff @(posedge Clock or posedge Resetn) begin
    // NOTE: sequential state uses non-blocking (<=) so every register sees
    // the pre-edge value of every other register, as real flops do.
    if (Resetn) begin
      state <= OCIOSO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Arbitration, next-state and datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch can be inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    grab      = 1'b0;
    // A lone request wins outright; on a tie either requester 0 is fixed
    // winner or the one that was not served last goes.
    pick1     = Req1 & (~Req0 | (~PRIO_FIXA & ~ultimo));
    case (state)
      OCIOSO: begin
        if (Req0 | Req1) begin
          take      = 1'b1;
          state_nxt = ACESSO;
        end
      end
      ACESSO: begin
        if (wr_q) begin
          state_nxt = CONCLUI;
        end else begin
          state_nxt = ESPERA;
          cnt_nxt   = LAT_INI;
        end
      end
      ESPERA: begin
        if (cnt == 2'd1) begin
          grab      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = CONCLUI;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      CONCLUI: state_nxt = OCIOSO;
      default: state_nxt = OCIOSO;
    endcase
  end

  // Registered memory-side outputs, owner tracking and read-data return.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      MemAddr    <= '0;
      MemDataOut <= '0;
      MemWrEn    <= 1'b0;
      wr_q       <= 1'b0;
      RData      <= '0;
      Grant      <= 2'b00;
      ultimo     <= 1'b1;   // requester 0 wins the first tie
    end else begin
      MemWrEn <= 1'b0;
      if (take) begin
        MemAddr    <= pick1 ? Addr1 : Addr0;
        MemDataOut <= pick1 ? Data1 : Data0;
        wr_q       <= pick1 ? Wr1   : Wr0;
        MemWrEn    <= pick1 ? Wr1   : Wr0;
        Grant      <= pick1 ? 2'b10 : 2'b01;
      end
      if (grab) begin
        RData <= MemDataIn;
      end
      if (state == CONCLUI) begin
        Grant  <= 2'b00;
        ultimo <= Grant[1];
      end
    end
  end

  // Moore completion and busy indications from the registered state.
  always_comb begin
    Busy = (state != OCIOSO);
    Ack0 = (state == CONCLUI) & Grant[0];
    Ack1 = (state == CONCLUI) & Grant[1];
  end

endmodule

// File: tb/tb_arbitro_memoria.sv
// Testbench for arbitro_memoria. Three instances cover the parameter space:
//   u0: RD_LAT=1, round-robin   u1: RD_LAT=2, round-robin
//   u2: RD_LAT=3, fixed priority
// Each instance has its own synchronous RAM model with the matching latency.
module tb_arbitro_memoria;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0 [3];
  logic        wr0  [3];
  logic [15:0] addr0[3];
  logic [15:0] data0[3];
  logic        req1 [3];
  logic        wr1  [3];
  logic [15:0] addr1[3];
  logic [15:0] data1[3];
  logic [15:0] mdin [3];
  logic [15:0] maddr[3];
  logic [15:0] mdout[3];
  logic        mwe  [3];
  logic [15:0] rdata[3];
  logic        ack0 [3];
  logic        ack1 [3];
  logic [1:0]  grant[3];
  logic        busy [3];

  int n_checks = 0;
  int n_fail   = 0;

  arbitro_memoria #(.RD_LAT(1), .PRIO_FIXA(1'b0)) u0 (
    .Clock(clk), .Resetn(rst),
    .Req0(req0[0]), .Addr0(addr0[0]), .Wr0(wr0[0]), .Data0(data0[0]),
    .Req1(req1[0]), .Addr1(addr1[0]), .Wr1(wr1[0]), .Data1(data1[0]),
    .MemDataIn(mdin[0]), .MemAddr(maddr[0]), .MemDataOut(mdout[0]),
    .MemWrEn(mwe[0]), .RData(rdata[0]), .Ack0(ack0[0]), .Ack1(ack1[0]),
    .Grant(grant[0]), .Busy(busy[0]));

  arbitro_memoria #(.RD_LAT(2), .PRIO_FIXA(1'b0)) u1 (
    .Clock(clk), .Resetn(rst),
    .Req0(req0[1]), .Addr0(addr0[1]), .Wr0(wr0[1]), .Data0(data0[1]),
    .Req1(req1[1]), .Addr1(addr1[1]), .Wr1(wr1[1]), .Data1(data1[1]),
    .MemDataIn(mdin[1]), .MemAddr(maddr[1]), .MemDataOut(mdout[1]),
    .MemWrEn(mwe[1]), .RData(rdata[1]), .Ack0(ack0[1]), .Ack1(ack1[1]),
    .Grant(grant[1]), .Busy(busy[1]));

  arbitro_memoria #(.RD_LAT(3), .PRIO_FIXA(1'b1)) u2 (
    .Clock(clk), .Resetn(rst),
    .Req0(req0[2]), .Addr0(addr0[2]), .Wr0(wr0[2]), .Data0(data0[2]),
    .Req1(req1[2]), .Addr1(addr1[2]), .Wr1(wr1[2]), .Data1(data1[2]),
    .MemDataIn(mdin[2]), .MemAddr(maddr[2]), .MemDataOut(mdout[2]),
    .MemWrEn(mwe[2]), .RData(rdata[2]), .Ack0(ack0[2]), .Ack1(ack1[2]),
    .Grant(grant[2]), .Busy(busy[2]));

  // Power-up RAM contents, indexed by the low address byte.
  function automatic logic [15:0] ram_init(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  // RAM models: write on MemWrEn, read data emerges (g+1) cycles after the
  // edge that samples the address.
  for (genvar g = 0; g < 3; g++) begin : g_ram
    logic [15:0] mem  [256];
    logic [15:0] pipe [3];
    initial for (int i = 0; i < 256; i++) mem[i] = ram_init(i[7:0]);
    always @(posedge clk) begin
      if (mwe[g]) mem[maddr[g][7:0]] <= mdout[g];
      pipe[0] <= mem[maddr[g][7:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mdin[g] = pipe[g];
  end

  // Observed control outputs packed as {Busy, Grant, Ack1, Ack0, MemWrEn}.
  function automatic logic [5:0] ctl(input int k);
    return {busy[k], grant[k], ack1[k], ack0[k], mwe[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 3; k++) begin
      req0[k] = 1'b0; wr0[k] = 1'b0; addr0[k] = '0; data0[k] = '0;
      req1[k] = 1'b0; wr1[k] = 1'b0; addr1[k] = '0; data1[k] = '0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ctl(k) !== 6'b0) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: got %b want 000000", k, ctl(k));
      end
      n_checks++;
      if (maddr[k] !== 16'h0 || mdout[k] !== 16'h0 || rdata[k] !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: got addr=%h dout=%h rdata=%h want 0", k,
                 maddr[k], mdout[k], rdata[k]);
      end
    end
    rst = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ctl(k) !== 6'b0) begin
        n_fail++; $display("FAIL idle_after_reset[%0d]: got %b want 000000", k, ctl(k));
      end
    end
  endtask

  task automatic test_single_write();
    req0[0] = 1'b1; addr0[0] = 16'h0010; wr0[0] = 1'b1; data0[0] = 16'hBEEF;
    tick();  // cycle 1
    n_checks++;
    if (ctl(0) !== 6'b1_01_0_0_1 || maddr[0] !== 16'h0010 || mdout[0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL wr_cycle1: got ctl=%b addr=%h dout=%h want 101001 0010 beef",
               ctl(0), maddr[0], mdout[0]);
    end
    tick();  // cycle 2
    n_checks++;
    if (ctl(0) !== 6'b1_01_0_1_0 || rdata[0] !== 16'h0) begin
      n_fail++;
      $display("FAIL wr_cycle2: got ctl=%b rdata=%h want 101010 0000", ctl(0), rdata[0]);
    end
    req0[0] = 1'b0;
    tick();  // cycle 3
    n_checks++;
    if (ctl(0) !== 6'b0) begin
      n_fail++; $display("FAIL wr_cycle3: got %b want 000000", ctl(0));
    end
  endtask

  task automatic test_single_read();
    // Place 16'h1234 at 0x0020 through the arbiter, then read it back.
    req0[1] = 1'b1; addr0[1] = 16'h0020; wr0[1] = 1'b1; data0[1] = 16'h1234;
    tick();
    tick();
    n_checks++;
    if (ctl(1) !== 6'b1_01_0_1_0) begin
      n_fail++; $display("FAIL rd_prep_ack: got %b want 101010", ctl(1));
    end
    req0[1] = 1'b0;
    tick();
    req1[1] = 1'b1; addr1[1] = 16'h0020; wr1[1] = 1'b0; data1[1] = 16'hDEAD;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_checks++;
      if (ctl(1) !== ((c == 4) ? 6'b1_10_1_0_0 : 6'b1_10_0_0_0) || maddr[1] !== 16'h0020) begin
        n_fail++;
        $display("FAIL rd_cycle%0d: got ctl=%b addr=%h want %b 0020", c, ctl(1), maddr[1],
                 (c == 4) ? 6'b1_10_1_0_0 : 6'b1_10_0_0_0);
      end
      if (c == 4) begin
        n_checks++;
        if (rdata[1] !== 16'h1234) begin
          n_fail++; $display("FAIL rd_data: got %h want 1234", rdata[1]);
        end
        req1[1] = 1'b0;
      end
    end
    tick();
    n_checks++;
    if (ctl(1) !== 6'b0 || rdata[1] !== 16'h1234) begin
      n_fail++; $display("FAIL rd_after: got ctl=%b rdata=%h want 000000 1234", ctl(1), rdata[1]);
    end
  endtask

  // Both requests held high: owner sequence is exp[] over n transactions,
  // each a 3-cycle write (ACESSO, CONCLUI, OCIOSO).
  task automatic run_tie(input int k, input int n, input logic [3:0] exp_own,
                         input logic drop0_last);
    logic [1:0] g;
    req0[k] = 1'b1; wr0[k] = 1'b1; addr0[k] = 16'h0050; data0[k] = 16'h5050;
    req1[k] = 1'b1; wr1[k] = 1'b1; addr1[k] = 16'h0060; data1[k] = 16'h6060;
    for (int t = 0; t < n; t++) begin
      g = exp_own[t] ? 2'b10 : 2'b01;
      tick();
      n_checks++;
      if (ctl(k) !== {1'b1, g, 3'b001} ||
          maddr[k] !== (exp_own[t] ? 16'h0060 : 16'h0050)) begin
        n_fail++;
        $display("FAIL tie[%0d] grant t%0d: got ctl=%b addr=%h want %b", k, t, ctl(k),
                 maddr[k], {1'b1, g, 3'b001});
      end
      tick();
      n_checks++;
      if (ctl(k) !== {1'b1, g, exp_own[t], ~exp_own[t], 1'b0}) begin
        n_fail++;
        $display("FAIL tie[%0d] ack t%0d: got %b want %b", k, t, ctl(k),
                 {1'b1, g, exp_own[t], ~exp_own[t], 1'b0});
      end
      if (drop0_last && t == n - 2) req0[k] = 1'b0;
      if (t == n - 1) begin
        req0[k] = 1'b0; req1[k] = 1'b0;
      end
      tick();
      n_checks++;
      if (ctl(k) !== 6'b0) begin
        n_fail++; $display("FAIL tie[%0d] idle t%0d: got %b want 000000", k, t, ctl(k));
      end
    end
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    run_tie(0, 4, 4'b1010, 1'b0);
  endtask

  task automatic test_tie_fixed();
    do_reset();
    run_tie(2, 4, 4'b1000, 1'b1);
  endtask

  task automatic test_reset_mid();
    // Leave u1 with requester 0 as last served so a tie would favour 1.
    req0[1] = 1'b1; wr0[1] = 1'b1; addr0[1] = 16'h0033; data0[1] = 16'h7777;
    tick();
    tick();
    req0[1] = 1'b0;
    tick();
    // u2 read; reset lands in the second ESPERA cycle.
    req0[2] = 1'b1; wr0[2] = 1'b0; addr0[2] = 16'h0030;
    tick();
    tick();
    tick();
    n_checks++;
    if (ctl(2) !== 6'b1_01_0_0_0) begin
      n_fail++; $display("FAIL mid_read_pre: got %b want 101000", ctl(2));
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl(2) !== 6'b0 || maddr[2] !== 16'h0 || rdata[2] !== 16'h0 || maddr[1] !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_read_reset: got ctl=%b addr=%h rdata=%h addr1=%h want 0", ctl(2),
               maddr[2], rdata[2], maddr[1]);
    end
    req0[2] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (ctl(2) !== 6'b0) begin
        n_fail++; $display("FAIL mid_read_no_ack c%0d: got %b want 000000", c, ctl(2));
      end
    end
    // u0 write; reset during ACESSO must drop MemWrEn immediately.
    req0[0] = 1'b1; wr0[0] = 1'b1; addr0[0] = 16'h0011; data0[0] = 16'hAAAA;
    tick();
    n_checks++;
    if (mwe[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_acc_pre: got wren=%b want 1", mwe[0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (ctl(0) !== 6'b0 || mdout[0] !== 16'h0) begin
      n_fail++; $display("FAIL mid_acc_reset: got ctl=%b dout=%h want 0", ctl(0), mdout[0]);
    end
    req0[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ctl(0) !== 6'b0) begin
      n_fail++; $display("FAIL mid_acc_no_ack: got %b want 000000", ctl(0));
    end
    // After reset a tie goes to requester 0 on both arbitration modes.
    for (int k = 1; k < 3; k++) begin
      req0[k] = 1'b1; wr0[k] = 1'b1; addr0[k] = 16'h0070;
      req1[k] = 1'b1; wr1[k] = 1'b1; addr1[k] = 16'h0071;
    end
    tick();
    for (int k = 1; k < 3; k++) begin
      n_checks++;
      if (grant[k] !== 2'b01) begin
        n_fail++; $display("FAIL tie_after_reset[%0d]: got %b want 01", k, grant[k]);
      end
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_sample_at_grant();
    req0[0] = 1'b1; wr0[0] = 1'b1; addr0[0] = 16'h0044; data0[0] = 16'h1111;
    tick();
    n_checks++;
    if (maddr[0] !== 16'h0044 || mdout[0] !== 16'h1111) begin
      n_fail++; $display("FAIL grab_c1: got %h %h want 0044 1111", maddr[0], mdout[0]);
    end
    addr0[0] = 16'hFFFF; data0[0] = 16'h2222; wr0[0] = 1'b0; req0[0] = 1'b0;
    tick();
    n_checks++;
    if (ctl(0) !== 6'b1_01_0_1_0 || maddr[0] !== 16'h0044 || mdout[0] !== 16'h1111) begin
      n_fail++;
      $display("FAIL grab_c2: got ctl=%b addr=%h dout=%h want 101010 0044 1111", ctl(0),
               maddr[0], mdout[0]);
    end
    tick();
    n_checks++;
    if (ctl(0) !== 6'b0 || maddr[0] !== 16'h0044) begin
      n_fail++; $display("FAIL grab_c3: got ctl=%b addr=%h want 000000 0044", ctl(0), maddr[0]);
    end
    idle_inputs();
  endtask

  // Random traffic against a transaction-level model: a transaction starts
  // when idle and someone requests, lasts 2 cycles (write) or 2+latency
  // cycles (read), and is followed by at least one idle cycle.
  task automatic test_random(input int k, input int cycles);
    logic [15:0] mm[256];
    int          lat = k + 1;
    bit          prio = (k == 2);
    bit          m_busy = 1'b0, own = 1'b0, mw = 1'b0, ult = 1'b1;
    int          t = 0, len = 0, hold0 = 0, hold1 = 0;
    logic [15:0] e_addr = '0, e_dout = '0, e_rdata = '0;
    logic [5:0]  e_ctl;
    for (int i = 0; i < 256; i++) mm[i] = ram_init(i[7:0]);
    do_reset();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      req0[k]  = (hold0 > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      req1[k]  = (hold1 > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      wr0[k]   = 1'($urandom);
      wr1[k]   = 1'($urandom);
      addr0[k] = 16'($urandom); addr0[k][7] = 1'b1;
      addr1[k] = 16'($urandom); addr1[k][7] = 1'b1;
      data0[k] = 16'($urandom);
      data1[k] = 16'($urandom);
      if (hold0 > 0) hold0--;
      if (hold1 > 0) hold1--;
      // Model advance for the coming edge.
      if (!m_busy) begin
        if (req0[k] || req1[k]) begin
          own    = req1[k] && (!req0[k] || (!prio && !ult));
          mw     = own ? wr1[k] : wr0[k];
          e_addr = own ? addr1[k] : addr0[k];
          e_dout = own ? data1[k] : data0[k];
          len    = mw ? 2 : 2 + lat;
          t      = 1;
          m_busy = 1'b1;
          if (mw) mm[e_addr[7:0]] = e_dout;
        end
      end else if (t == len) begin
        m_busy = 1'b0;
        ult    = own;
      end else begin
        t++;
        if (t == len && !mw) e_rdata = mm[e_addr[7:0]];
      end
      tick();
      e_ctl = m_busy ? {1'b1, own ? 2'b10 : 2'b01, (t == len) && own, (t == len) && !own,
                        (t == 1) && mw} : 6'b0;
      n_checks++;
      if (ctl(k) !== e_ctl) begin
        n_fail++; $display("FAIL rnd[%0d] ctl c%0d: got %b want %b", k, cyc, ctl(k), e_ctl);
      end
      n_checks++;
      if (maddr[k] !== e_addr || mdout[k] !== e_dout) begin
        n_fail++;
        $display("FAIL rnd[%0d] mem c%0d: got %h %h want %h %h", k, cyc, maddr[k], mdout[k],
                 e_addr, e_dout);
      end
      n_checks++;
      if (rdata[k] !== e_rdata) begin
        n_fail++; $display("FAIL rnd[%0d] rdata c%0d: got %h want %h", k, cyc, rdata[k], e_rdata);
      end
      // The acknowledged requester stays low through the following idle cycle.
      if (m_busy && t == len) begin
        if (own) hold1 = 2; else hold0 = 2;
      end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_single_read();
    test_tie_round_robin();
    test_tie_fixed();
    test_reset_mid();
    test_sample_at_grant();
    for (int k = 0; k < 3; k++) test_random(k, 400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit");
  end

endmodule
